quad_paddle_decoder: RTL and testbench

//  Turns raw quadrature-encoder pins (quad_a/quad_b) into a debounced, saturating paddle position
//  for the pong game datapath, which draws the paddle from paddle_pos.
//  - Synchronises and glitch-filters the pins, then decodes Gray-code steps.
//  - Tracks a live position; publishes it once per video frame on frame_tick, so the paddle never tears mid-frame.

---
 rtl/pong_pkg.sv | 51 +++++
 rtl/quad_paddle_decoder_if.sv | 42 ++++
 rtl/quad_paddle_decoder_filter.sv | 37 +++
 rtl/quad_paddle_decoder.sv | 113 +++++++++++
 tb/tb_quad_paddle_decoder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
//   Shared types and constants for the pong game datapath.
//   - PADDLE_POS_W / PADDLE_MAX_POS : default paddle position width and limit.
//   - quad_state_t : quadrature pin pair {A,B}, each value is its own pin level.
//   - dir_t        : direction of the last accepted encoder step.
//   - quad_step_t  : result of classifying one filtered pin transition.
//   - quad_decode(): classifies an old->new pin pair as up/down/illegal/none.
// -----------------------------------------------------------------------------
package pong_pkg;

    localparam int PADDLE_POS_W   = 9;
    localparam int PADDLE_MAX_POS = 511;

    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q11 = 2'b11,
        Q10 = 2'b10
    } quad_state_t;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DN,
        STEP_BAD
    } quad_step_t;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; a both-bits change is illegal.
    function automatic quad_step_t quad_decode(input quad_state_t old_s,
                                               input quad_state_t new_s);
        quad_state_t fwd;
        quad_state_t rev;
        case (old_s)
            Q00:     begin fwd = Q01; rev = Q10; end
            Q01:     begin fwd = Q11; rev = Q00; end
            Q11:     begin fwd = Q10; rev = Q01; end
            default: begin fwd = Q00; rev = Q11; end
        endcase
        if (new_s == old_s)    return STEP_NONE;
        else if (new_s == fwd) return STEP_UP;
        else if (new_s == rev) return STEP_DN;
        else                   return STEP_BAD;
    endfunction

endpackage

// File: rtl/quad_paddle_decoder_if.sv
// -----------------------------------------------------------------------------
// quad_paddle_if
//   Signal bundle between the encoder/video side and quad_paddle_decoder.
//   Optional macro: QUAD_ERR_EN adds the 8-bit err_cnt signal.
//   quad_a, quad_b : raw encoder pins (asynchronous to clk)
//   frame_tick     : one-cycle per-frame publish strobe
//   paddle_pos     : frame-stable paddle position
//   pos_valid      : one-cycle pulse, paddle_pos just updated
//   dir            : direction of last accepted step (1 = up)
//   err_cnt        : saturating illegal-transition count (QUAD_ERR_EN only)
//   modport master : drives pins/frame_tick, observes outputs
//   modport slave  : the decoder
// -----------------------------------------------------------------------------
interface quad_paddle_if #(
    parameter int POS_W = 9
);
    logic             quad_a;
    logic             quad_b;
    logic             frame_tick;
    logic [POS_W-1:0] paddle_pos;
    logic             pos_valid;
    logic             dir;
`ifdef QUAD_ERR_EN
    logic [7:0]       err_cnt;
`endif

    modport master (
        output quad_a, quad_b, frame_tick,
        input  paddle_pos, pos_valid, dir
`ifdef QUAD_ERR_EN
        , input err_cnt
`endif
    );

    modport slave (
        input  quad_a, quad_b, frame_tick,
        output paddle_pos, pos_valid, dir
`ifdef QUAD_ERR_EN
        , output err_cnt
`endif
    );
endinterface

// File: rtl/quad_paddle_decoder_filter.sv
// -----------------------------------------------------------------------------
// quad_input_filter
//   Two-flop synchroniser plus a FILT_LEN-deep agreement window for one pin.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_pin      : raw asynchronous pin
//   o_level    : current second-stage synchronised level
//   o_stable   : the last FILT_LEN synchronised samples are all equal
// -----------------------------------------------------------------------------
module quad_input_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_stable
);
    logic                r_sync1;
    // r_win[0] is the second synchroniser flop; higher bits are its history.
    logic [FILT_LEN-1:0] r_win;

    // NOTE: every flop here, window included, is reset -- the filter must come up
    // agreeing on a known level so priming sees a clean first acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_win   <= '0;
        end else begin
            // NOTE: non-blocking so every stage shifts from the pre-edge values.
            r_sync1 <= i_pin;
            r_win   <= {r_win[FILT_LEN-2:0], r_sync1};
        end
    end

    assign o_level  = r_win[0];
    assign o_stable = (&r_win) | (~|r_win);
endmodule

// File: rtl/quad_paddle_decoder.sv
// -----------------------------------------------------------------------------
// quad_paddle_decoder
//   Filters quadrature pins, decodes Gray-code steps into a saturating position,
//   and publishes that position once per frame so the paddle never tears.
//   Optional macro: QUAD_ERR_EN enables the illegal-transition counter err_cnt.
//   clk        : pixel clock
//   rst_n      : asynchronous active-low reset
//   bus        : quad_paddle_if.slave (pins, frame_tick, paddle_pos, pos_valid,
//                dir, err_cnt)
// -----------------------------------------------------------------------------
module quad_paddle_decoder
    import pong_pkg::*;
#(
    parameter int POS_W    = PADDLE_POS_W,
    parameter int MAX_POS  = PADDLE_MAX_POS,
    parameter int INIT_POS = 0,
    parameter int FILT_LEN = 4
) (
    input logic          clk,
    input logic          rst_n,
    quad_paddle_if.slave bus
);
    logic        w_lvl_a, w_stb_a, w_lvl_b, w_stb_b;
    quad_state_t w_new_ab;
    quad_step_t  w_step;
    logic        w_accept;

    quad_state_t      r_filt_ab;
    logic             r_primed;
    logic [POS_W-1:0] r_pos_raw;
    logic [POS_W-1:0] r_paddle_pos;
    logic             r_pos_valid;
    dir_t             r_dir;

    quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_pin    (bus.quad_a),
        .o_level  (w_lvl_a),
        .o_stable (w_stb_a)
    );

    quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_pin    (bus.quad_b),
        .o_level  (w_lvl_b),
        .o_stable (w_stb_b)
    );

    // Each channel adopts its new level independently once its window agrees;
    // both flipping in the same cycle is what makes a transition illegal.
    always_comb begin
        // NOTE: defaults first so no path leaves a combinational output unassigned.
        w_new_ab = r_filt_ab;
        if (w_stb_a) w_new_ab[1] = w_lvl_a;
        if (w_stb_b) w_new_ab[0] = w_lvl_b;
        w_accept = (w_new_ab != r_filt_ab);
        w_step   = quad_decode(r_filt_ab, w_new_ab);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_ab    <= Q00;
            r_primed     <= 1'b0;
            r_pos_raw    <= POS_W'(INIT_POS);
            r_paddle_pos <= POS_W'(INIT_POS);
            r_pos_valid  <= 1'b0;
            r_dir        <= DIR_DN;
        end else begin
            // Publish samples pos_raw before this edge's update lands.
            r_pos_valid <= bus.frame_tick;
            if (bus.frame_tick) r_paddle_pos <= r_pos_raw;

            if (w_accept) begin
                r_filt_ab <= w_new_ab;
                r_primed  <= 1'b1;
                // The first accepted level after reset is a reference, not a step.
                if (r_primed) begin
                    case (w_step)
                        STEP_UP: begin
                            r_dir <= DIR_UP;
                            if (r_pos_raw != POS_W'(MAX_POS)) r_pos_raw <= r_pos_raw + 1'b1;
                        end
                        STEP_DN: begin
                            r_dir <= DIR_DN;
                            if (r_pos_raw != '0) r_pos_raw <= r_pos_raw - 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef QUAD_ERR_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_accept && r_primed && (w_step == STEP_BAD) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.err_cnt = r_err_cnt;
`endif

    assign bus.paddle_pos = r_paddle_pos;
    assign bus.pos_valid  = r_pos_valid;
    assign bus.dir        = r_dir;
endmodule

// File: tb/tb_quad_paddle_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_paddle_decoder
//   Scoreboard bench: every frame_tick pushes the reference model's position,
//   direction and error count; a monitor pops and compares on each pos_valid.
//   The reference model works on Gray-sequence indices and integer arithmetic.
// -----------------------------------------------------------------------------
module tb_quad_paddle_decoder;
    localparam int POS_W    = 9;
    localparam int MAX_POS  = 511;
    localparam int FILT_LEN = 4;
    localparam logic [1:0] SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    typedef struct {
        int pos;
        int dir;
        int err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    quad_paddle_if #(.POS_W(POS_W)) bus ();

    quad_paddle_decoder #(
        .POS_W    (POS_W),
        .MAX_POS  (MAX_POS),
        .INIT_POS (0),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    // Reference model state.
    int         m_pos    = 0;
    int         m_dir    = 0;
    int         m_err    = 0;
    bit         m_primed = 1'b0;
    logic [1:0] m_filt   = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int gray_idx(input logic [1:0] p);
        for (int i = 0; i < 4; i++) if (SEQ[i] == p) return i;
        return 0;
    endfunction

    // Apply one settled pin level to the model.
    task automatic model_apply(input logic [1:0] p);
        int d;
        if (p == m_filt) return;
        if (!m_primed) begin
            m_primed = 1'b1;
            m_filt   = p;
            return;
        end
        d = (gray_idx(p) - gray_idx(m_filt) + 4) % 4;
        if (d == 1) begin
            m_dir = 1;
            if (m_pos < MAX_POS) m_pos++;
        end else if (d == 3) begin
            m_dir = 0;
            if (m_pos > 0) m_pos--;
        end else begin
            if (m_err < 255) m_err++;
        end
        m_filt = p;
    endtask

    task automatic model_reset();
        m_pos = 0; m_dir = 0; m_err = 0; m_primed = 1'b0; m_filt = 2'b00;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [1:0] pins();
        return {bus.quad_a, bus.quad_b};
    endfunction

    task automatic push_exp();
        exp_t e;
        e.pos = m_pos; e.dir = m_dir; e.err = m_err;
        sb_q.push_back(e);
    endtask

    task automatic set_pins(input logic [1:0] p, input int hold);
        {bus.quad_a, bus.quad_b} = p;
        cyc(hold);
        model_apply(p);
    endtask

    task automatic step(input int d, input int hold);
        set_pins(SEQ[(gray_idx(pins()) + d + 4) % 4], hold);
    endtask

    // Flip one channel for len cycles, then restore it.
    task automatic glitch(input int chan, input int len, input int hold);
        logic [1:0] orig;
        logic [1:0] flip;
        orig = pins();
        flip = orig ^ ((chan == 0) ? 2'b10 : 2'b01);
        {bus.quad_a, bus.quad_b} = flip;
        cyc(len);
        {bus.quad_a, bus.quad_b} = orig;
        cyc(hold);
        if (len >= FILT_LEN) begin
            model_apply(flip);
            model_apply(orig);
        end
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        push_exp();
        cyc(1);
        bus.frame_tick = 1'b0;
        cyc(1);
    endtask

    // Monitor: one expectation per pos_valid pulse.
    always @(negedge clk) begin
        if (rst_n && bus.pos_valid) begin
            if (sb_q.size() == 0) begin
                check("spurious_pos_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("paddle_pos", 32'(bus.paddle_pos), e.pos);
                check("dir", 32'(bus.dir), e.dir);
`ifdef QUAD_ERR_EN
                check("err_cnt", 32'(bus.err_cnt), e.err);
`endif
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.quad_a     = 1'b1;
        bus.quad_b     = 1'b1;
        bus.frame_tick = 1'b0;
        rst_n          = 1'b0;
        cyc(3);
        check("reset_paddle_pos", 32'(bus.paddle_pos), 0);
        check("reset_pos_valid", 32'(bus.pos_valid), 0);
        check("reset_dir", 32'(bus.dir), 0);
`ifdef QUAD_ERR_EN
        check("reset_err_cnt", 32'(bus.err_cnt), 0);
`endif

        // Idle at 11 out of reset: primes only.
        @(negedge clk) rst_n = 1'b1;
        cyc(20);
        model_apply(2'b11);
        frame();

        // Walk down to 00 (saturates at 0), then one full forward cycle.
        set_pins(2'b01, 8);
        set_pins(2'b00, 8);
        set_pins(2'b01, 8);
        set_pins(2'b11, 8);
        set_pins(2'b10, 8);
        set_pins(2'b00, 8);
        frame();

        // Saturation at both ends.
        repeat (515) step(1, 7);
        frame();
        repeat (600) step(-1, 7);
        frame();

        // Glitch rejection and acceptance.
        glitch(0, 3, 10);
        frame();
        set_pins(pins() ^ 2'b10, 8);
        frame();
        glitch(0, 4, 10);
        frame();

        // Illegal jump 00 -> 11.
        while (pins() != 2'b00) step(1, 7);
        frame();
        set_pins(2'b11, 8);
        frame();

        // Publish coinciding with a 7 -> 8 update, then back-to-back tick.
        while (m_pos != 7) step((m_pos < 7) ? 1 : -1, 7);
        begin
            logic [1:0] np;
            np = SEQ[(gray_idx(pins()) + 1) % 4];
            {bus.quad_a, bus.quad_b} = np;
            cyc(5);
            bus.frame_tick = 1'b1;
            push_exp();
            cyc(1);
            model_apply(np);
            push_exp();
            cyc(1);
            bus.frame_tick = 1'b0;
            cyc(6);
        end

        // Randomised traffic.
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5)      step(($urandom_range(0, 1) != 0) ? 1 : -1, $urandom_range(7, 12));
            else if (r == 6) set_pins(pins() ^ 2'b11, $urandom_range(7, 12));
            else if (r == 7) glitch($urandom_range(0, 1), $urandom_range(1, 6), $urandom_range(7, 12));
            else             frame();
        end

        // Reset in the middle of operation.
        while (m_pos < 3) step(1, 7);
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.frame_tick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_paddle_pos", 32'(bus.paddle_pos), 0);
        check("midrst_pos_valid", 32'(bus.pos_valid), 0);
        check("midrst_dir", 32'(bus.dir), 0);
`ifdef QUAD_ERR_EN
        check("midrst_err_cnt", 32'(bus.err_cnt), 0);
`endif
        model_reset();
        cyc(3);
        @(negedge clk) rst_n = 1'b1;
        cyc(10);
        model_apply(pins());
        frame();
        repeat (5) step(1, 8);
        frame();

        // Drain the scoreboard within a bounded window.
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) cyc(1);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
